// File: rtl/pc_exception_unit.sv
// pc_exception_unit
//   Program counter and EPC registers sitting just after the PC-source mux of
//   a multi-cycle MIPS datapath, plus the small sequencer that performs
//   exception entry: save the faulting PC, fetch the handler byte from a fixed
//   vector address, then load that byte (zero-extended) into PC.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high
//   pc_next        in  32   PC-source mux output
//   pc_write       in   1   unconditional PC write enable
//   pc_write_cond  in   1   conditional (branch) PC write enable
//   branch_taken   in   1   branch condition, qualifies pc_write_cond
//   exc_opcode     in   1   invalid-opcode exception request (highest priority)
//   exc_overflow   in   1   overflow exception request
//   exc_div0       in   1   divide-by-zero exception request (lowest priority)
//   mem_rdata      in  32   memory read data
//   pc             out 32   program counter
//   epc            out 32   exception PC (feeds the mux EPC input)
//   exc_mem_req    out  1   unit owns the memory address port this cycle
//   exc_mem_addr   out 32   vector address, 0 when not requesting
//   exc_busy       out  1   exception sequence in progress
//   exc_cause      out  2   last cause: 0 none, 1 opcode, 2 overflow, 3 div0
module pc_exception_unit #(
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        branch_taken,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        exc_mem_req,
  output logic [31:0] exc_mem_addr,
  output logic        exc_busy,
  output logic [1:0]  exc_cause
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Last WAIT count value; WAIT lasts exactly MEM_LAT cycles.
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] epc_r, epc_s;
  logic [1:0]  cause_r, cause_s;
  logic [31:0] vec_r, vec_s;
  logic        busy_r, busy_s;
  logic [31:0] addr_r, addr_s;
  logic        exc_any_s;

  assign exc_any_s = exc_opcode | exc_overflow | exc_div0;

  // Next-state, datapath update and next-output computation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pc_s    = pc_r;
    epc_s   = epc_r;
    cause_s = cause_r;
    vec_s   = vec_r;
    case (state_r)
      ST_IDLE: begin
        if (exc_any_s) begin
          // Exception entry wins over any same-cycle PC write.
          epc_s   = pc_r - 32'd4;
          cnt_s   = 3'd0;
          state_s = ST_WAIT;
          if (exc_opcode) begin
            cause_s = 2'd1;
            vec_s   = VEC_OPCODE;
          end else if (exc_overflow) begin
            cause_s = 2'd2;
            vec_s   = VEC_OVF;
          end else begin
            cause_s = 2'd3;
            vec_s   = VEC_DIV0;
          end
        end else if (pc_write || (pc_write_cond && branch_taken)) begin
          pc_s = pc_next;
        end else begin
          pc_s = pc_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r == LAT_LAST) begin
          cnt_s   = 3'd0;
          state_s = ST_LOAD;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      ST_LOAD: begin
        pc_s    = {24'd0, mem_rdata[7:0]};
        state_s = ST_IDLE;
      end
      default: begin
        cnt_s   = 3'd0;
        state_s = ST_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they align with it.
    busy_s = (state_s != ST_IDLE);
    if (busy_s) begin
      addr_s = vec_s;
    end else begin
      addr_s = 32'd0;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      pc_r    <= 32'd0;
      epc_r   <= 32'd0;
      cause_r <= 2'd0;
      vec_r   <= 32'd0;
      busy_r  <= 1'b0;
      addr_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pc_r    <= pc_s;
      epc_r   <= epc_s;
      cause_r <= cause_s;
      vec_r   <= vec_s;
      busy_r  <= busy_s;
      addr_r  <= addr_s;
    end
  end

  assign pc           = pc_r;
  assign epc          = epc_r;
  assign exc_cause    = cause_r;
  assign exc_busy     = busy_r;
  assign exc_mem_req  = busy_r;
  assign exc_mem_addr = addr_r;

endmodule
